// File: rtl/ldi_dps_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : ldi_dps_arbiter
// Purpose : Round-robin sharing of one PLL dynamic-phase-shift port among
//           NUM_CH requesters, with phasestep/phasedone handshake and timeout.
// Rev     : 1.0
// ============================================================================
module ldi_dps_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int CH_W           = 2,
    parameter int STEP_CYCLES    = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int GAP_CYCLES     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic [NUM_CH-1:0]     req,
    input  logic [NUM_CH-1:0]     req_dir,
    input  logic [5*NUM_CH-1:0]   req_cntsel,
    output logic [NUM_CH-1:0]     ack,
    output logic [NUM_CH-1:0]     err,
    output logic                  busy,
    output logic [CH_W-1:0]       grant_id,
    output logic                  pll_phasestep,
    output logic                  pll_updn,
    output logic [4:0]            pll_cntsel,
    input  logic                  pll_phasedone
);

    localparam int c_tmr_max =
        (TIMEOUT_CYCLES > GAP_CYCLES)
            ? ((TIMEOUT_CYCLES > STEP_CYCLES) ? TIMEOUT_CYCLES : STEP_CYCLES)
            : ((GAP_CYCLES > STEP_CYCLES) ? GAP_CYCLES : STEP_CYCLES);
    localparam int c_tmr_w = $clog2(c_tmr_max + 1);

    localparam logic [c_tmr_w-1:0] c_to_last   = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_step_last = c_tmr_w'(STEP_CYCLES - 1);
    localparam logic [c_tmr_w-1:0] c_gap_last  = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [CH_W:0]      c_num_ch    = (CH_W + 1)'(NUM_CH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_STEP      = 3'd1,
        S_WAIT_HIGH = 3'd2,
        S_DONE      = 3'd3,
        S_FAIL      = 3'd4,
        S_GAP       = 3'd5
    } state_t;

    state_t               r_state;
    logic [c_tmr_w-1:0]   r_timer;
    logic [CH_W-1:0]      r_ptr;
    logic                 r_pd_meta;
    logic                 r_pd_s;

    logic [NUM_CH-1:0]    w_req_rot;
    logic                 w_found;
    logic [CH_W-1:0]      w_offset;
    logic [CH_W:0]        w_sum;
    logic [CH_W-1:0]      w_win;
    logic [CH_W:0]        w_nsum;
    logic [CH_W-1:0]      w_next_ptr;
    logic                 w_win_dir;
    logic [4:0]           w_win_cnt;
    logic [NUM_CH-1:0]    w_grant_oh;
    logic                 w_timed_out;
    logic                 w_step_exit;

    // Rotate requests so bit 0 is the channel where the search starts.
    assign w_req_rot = NUM_CH'({req, req} >> r_ptr);

    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (w_req_rot[k]) begin
                w_found  = 1'b1;
                w_offset = CH_W'(k);
            end
        end
    end

    assign w_sum      = {1'b0, r_ptr} + {1'b0, w_offset};
    assign w_win      = (w_sum >= c_num_ch) ? CH_W'(w_sum - c_num_ch) : CH_W'(w_sum);
    assign w_nsum     = {1'b0, w_win} + (CH_W + 1)'(1);
    assign w_next_ptr = (w_nsum >= c_num_ch) ? '0 : w_nsum[CH_W-1:0];

    always_comb begin
        w_win_dir  = 1'b0;
        w_win_cnt  = '0;
        w_grant_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_win == CH_W'(i)) begin
                w_win_dir = req_dir[i];
                w_win_cnt = req_cntsel[5*i +: 5];
            end
            if (grant_id == CH_W'(i)) begin
                w_grant_oh[i] = 1'b1;
            end
        end
    end

    assign w_timed_out = (r_timer == c_to_last);
    assign w_step_exit = (r_timer >= c_step_last) && !r_pd_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pd_meta     <= 1'b1;
            r_pd_s        <= 1'b1;
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_ptr         <= '0;
            ack           <= '0;
            err           <= '0;
            busy          <= 1'b0;
            grant_id      <= '0;
            pll_phasestep <= 1'b0;
            pll_updn      <= 1'b0;
            pll_cntsel    <= '0;
        end else begin
            r_pd_meta <= pll_phasedone;
            r_pd_s    <= r_pd_meta;
            ack       <= '0;
            err       <= '0;
            if (r_timer != c_to_last) begin
                r_timer <= r_timer + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (pll_locked && w_found) begin
                        grant_id      <= w_win;
                        pll_updn      <= w_win_dir;
                        pll_cntsel    <= w_win_cnt;
                        r_ptr         <= w_next_ptr;
                        pll_phasestep <= 1'b1;
                        busy          <= 1'b1;
                        r_timer       <= '0;
                        r_state       <= S_STEP;
                    end
                end
                S_STEP: begin
                    if (!pll_locked || (w_timed_out && !w_step_exit)) begin
                        err           <= w_grant_oh;
                        pll_phasestep <= 1'b0;
                        r_timer       <= '0;
                        r_state       <= S_FAIL;
                    end else if (w_step_exit) begin
                        pll_phasestep <= 1'b0;
                        r_timer       <= '0;
                        r_state       <= S_WAIT_HIGH;
                    end
                end
                S_WAIT_HIGH: begin
                    if (!pll_locked || (w_timed_out && !r_pd_s)) begin
                        err     <= w_grant_oh;
                        r_timer <= '0;
                        r_state <= S_FAIL;
                    end else if (r_pd_s) begin
                        ack     <= w_grant_oh;
                        r_timer <= '0;
                        r_state <= S_DONE;
                    end
                end
                S_DONE, S_FAIL: begin
                    r_timer <= '0;
                    r_state <= S_GAP;
                end
                S_GAP: begin
                    if (r_timer == c_gap_last) begin
                        busy    <= 1'b0;
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    busy          <= 1'b0;
                    pll_phasestep <= 1'b0;
                    r_timer       <= '0;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/ldi_dps_arbiter.md
Name: ldi_dps_arbiter

Overview:
- Shares one PLL dynamic-phase-shift port among NUM_CH independent LVDS receive channels, each with its own phase-search controller.
- Each requester posts a single-step request (direction plus counter select).
- The arbiter grants requests round-robin, sequences the PLL phasestep/phasedone handshake with timeout, and returns a per-channel ack or err pulse.
- Sits between the per-channel DPS controllers and the PLL reconfiguration pins.

Parameters:
- NUM_CH, 4, number of requesting channels (2..8).
- CH_W, 2, width of grant_id; must be ≥ clog2(NUM_CH), minimum 1.
- STEP_CYCLES, 2, minimum number of cycles pll_phasestep is held high.
- TIMEOUT_CYCLES, 1024, per-phase handshake timeout in clk cycles.
- GAP_CYCLES, 4, idle cycles after each ack/err before the next grant.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- pll_locked, in, 1, PLL lock, already synchronous to clk.
- req, in, NUM_CH, per-channel step request level.
- req_dir, in, NUM_CH, per-channel direction; 1 = up.
- req_cntsel, in, 5*NUM_CH, per-channel counter select; channel i uses bits [5i+4:5i].
- ack, out, NUM_CH, one-cycle pulse when the granted step completes.
- err, out, NUM_CH, one-cycle pulse when the granted step times out or is aborted.
- busy, out, 1, high in every state except IDLE.
- grant_id, out, CH_W, index of the current or last granted channel.
- pll_phasestep, out, 1, PLL phasestep.
- pll_updn, out, 1, PLL phaseupdown.
- pll_cntsel, out, 5, PLL cntsel.
- pll_phasedone, in, 1, PLL phasedone; asynchronous; active-low while a shift is in progress.

Behaviour:
- **Reset (sync, active-high):** all outputs 0, rr pointer = 0, state = IDLE, synchronizer = 2'b11. Reset applies on the next clk edge even mid-operation: pll_phasestep drops to 0 and no ack/err is issued.
- **Synchronizer:** pll_phasedone passes through a 2-flop synchronizer; pd_s is its output, 2 cycles of latency.
- **Request rule:** a requester holds req, req_dir and req_cntsel stable until it sees its ack or err. req_dir and req_cntsel are latched at grant. Deasserting req after grant does not cancel the step; ack/err is still pulsed.
- **Arbitration:** round-robin. Search begins at (last grant + 1) mod NUM_CH. The first asserted req wins. The pointer updates only on grant.
- **State machine (registered outputs):**
  - IDLE: if pll_locked and |req → latch the winner into grant_id, pll_updn and pll_cntsel; go to STEP. pll_phasestep rises the cycle after req is sampled.
  - STEP: pll_phasestep = 1; hold cnt increments.
    - Exit to WAIT_HIGH when hold cnt ≥ STEP_CYCLES-1 and pd_s == 0.
    - If pd_s does not go low within TIMEOUT_CYCLES → FAIL.
  - WAIT_HIGH: pll_phasestep = 0.
    - pd_s == 1 → DONE.
    - TIMEOUT_CYCLES elapsed → FAIL.
  - DONE: ack[grant_id] = 1 for exactly one cycle; go to GAP.
  - FAIL: err[grant_id] = 1 for exactly one cycle; go to GAP.
  - GAP: wait GAP_CYCLES cycles, then IDLE. No grant is made during GAP.
- **Timer:** a single counter, cleared on every state entry, saturating at TIMEOUT_CYCLES-1. Timeout fires when the counter equals TIMEOUT_CYCLES-1 and the exit condition is still unmet.
- **pll_locked deasserted:**
  - In STEP or WAIT_HIGH: abort to FAIL next cycle; pll_phasestep is forced to 0 that same cycle.
  - In IDLE: no grants are made.
- **Other outputs:**
  - pll_updn and pll_cntsel hold their latched values from grant until the next grant. They never change while pll_phasestep = 1.
  - ack and err are mutually exclusive and one-hot, and never both fire for one grant.
  - busy = 1 in STEP, WAIT_HIGH, DONE, FAIL and GAP.
- **Simultaneous requests:** exactly one grant per IDLE visit. Every channel holding req is serviced within NUM_CH grants (no starvation).

Test Plan:
- Single request: req = 4'b0001, dir = 1, cntsel = 5'd2. PLL model drops phasedone 3 cycles after phasestep rises and raises it 5 cycles later → pll_phasestep high ≥ 2 cycles, pll_updn = 1, pll_cntsel = 2, one ack[0] pulse, busy high through GAP, no err.
- Fairness: req = 4'b1111 held and re-requested after each ack → grant order 0,1,2,3,0; exactly one ack per grant; GAP of 4 cycles observed between ack and the next phasestep edge.
- Timeout: PLL model never lowers phasedone; TIMEOUT_CYCLES = 16 → phasestep drops and err[granted] pulses 16 cycles after STEP entry; then the next requester is granted normally.
- pll_locked falls during WAIT_HIGH → err pulse, phasestep 0. While locked is low with req = 4'b0010, no grant and busy = 0; the grant occurs on the first cycle locked returns.
- Sync reset asserted during STEP → next cycle all outputs 0, no ack/err; after release the pending req = 4'b0100 is granted to channel 2 with the pointer restarted at 0.
- Requester drops req one cycle after grant → step completes and ack still pulses once; req_dir changes after grant do not alter pll_updn.
